// File: rtl/dice_serial_pkg.sv
// ----------------------------------------------------------------------------
// dice_serial_pkg : state encoding and default sizing shared by serial TX/RX.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dice_serial_pkg;

    localparam int DEF_CYCLES_PER_BIT = 10;
    localparam int DEF_DATA_W         = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } serial_state_e;

endpackage

`default_nettype wire

// File: rtl/bit_timer.sv
// ----------------------------------------------------------------------------
// bit_timer : counts CYCLES_PER_BIT clocks and flags the last cycle of a bit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bit_timer #(
    parameter int CYCLES_PER_BIT = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic bit_tick_o
);

    localparam int               CNT_W    = $clog2(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick marks the final cycle of the current bit; the counter restarts at 0.
    assign bit_tick_o = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/piso.sv
// ----------------------------------------------------------------------------
// piso : parallel-in serial-out transmitter (start, LSB-first data, stop).
// Define PISO_PARITY_EN to add an even-parity bit before stop.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module piso
    import dice_serial_pkg::*;
#(
    parameter int CYCLES_PER_BIT = DEF_CYCLES_PER_BIT,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_start,
    output logic              o_ready,
    output logic              o_data_out,
    output logic              o_done
);

    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    serial_state_e     state_q;
    serial_state_e     state_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic              line_q;
    logic              line_d;
    logic              bit_tick;
`ifdef PISO_PARITY_EN
    logic              parity_q;
    logic              parity_d;
`endif

    bit_timer #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (state_q == IDLE),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (i_start) begin
                    shreg_d = i_data_in;
`ifdef PISO_PARITY_EN
                    parity_d = ^i_data_in;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The line register loads the level belonging to the next state, so it
    // changes on the same edge as the state and never glitches.
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            START:  line_d = 1'b0;
            SHIFT:  line_d = shreg_d[0];
`ifdef PISO_PARITY_EN
            PARITY: line_d = parity_d;
`endif
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            line_q    <= 1'b1;
`ifdef PISO_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            line_q    <= line_d;
`ifdef PISO_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_data_out = line_q;
    assign o_done     = (state_q == STOP) && bit_tick;

endmodule

`default_nettype wire

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 SHALL provide parameter CYCLES_PER_BIT, default 10, clock cycles each serial bit is held on the line (legal range 2..255).
REQ-002 SHALL provide parameter DATA_W, default 7, parallel word width in bits.
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port i_data_in  input  DATA_W  parallel word to transmit.
REQ-006 SHALL provide port i_start  input  1  transmit request; sampled only while o_ready=1.
REQ-007 SHALL provide port o_ready  output  1  high when a new word can be accepted.
REQ-008 SHALL provide port o_data_out  output  1  serial line, idles high.
REQ-009 SHALL provide port o_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL use states IDLE, START, SHIFT, STOP (plus PARITY when REQ-025 applies), with encoding taken from the shared package.
REQ-011 SHALL, in IDLE, hold o_data_out=1 and o_ready=1.
REQ-012 SHALL, on a rising edge in IDLE with i_start=1, latch i_data_in into a shift register, deassert o_ready, and enter START.
REQ-013 SHALL drive o_data_out=0 for exactly CYCLES_PER_BIT cycles in START.
REQ-014 SHALL, in SHIFT, transmit DATA_W bits LSB first, each held for exactly CYCLES_PER_BIT cycles; a bit counter selects the exit.
REQ-015 SHALL drive o_data_out=1 for CYCLES_PER_BIT cycles in STOP, then return to IDLE.
REQ-016 SHALL pulse o_done high for exactly one cycle, on the final cycle of STOP.
REQ-017 SHALL reassert o_ready on the first IDLE cycle after STOP, giving a frame of (DATA_W+2)*CYCLES_PER_BIT cycles from START entry to IDLE.
REQ-018 SHALL ignore i_start and i_data_in changes while o_ready=0; latched data is unaffected.
REQ-019 SHALL accept a new word back-to-back when i_start=1 in the first IDLE cycle, giving exactly one idle-high cycle between frames.
REQ-020 SHALL size the cycle counter to $clog2(CYCLES_PER_BIT); the counter resets to 0 at each bit boundary and never wraps mid-bit.
REQ-021 SHALL drive o_data_out from a register, so the line is glitch-free.

Reset
REQ-022 SHALL, on reset_n=0 at any time, immediately force state=IDLE, o_data_out=1, o_ready=1, o_done=0, and clear all counters and the shift register.
REQ-023 SHALL abandon a frame cut by reset mid-transmission, with no o_done pulse; after release, the block is idle and waits for i_start.
REQ-024 SHALL start its first accepted frame on the first rising edge after reset_n deasserts when i_start=1.

Configuration
REQ-025 SHALL, when macro PISO_PARITY_EN is defined, insert a PARITY state between SHIFT and STOP that transmits the even-parity bit (XOR of the latched word) for CYCLES_PER_BIT cycles; the frame becomes (DATA_W+3)*CYCLES_PER_BIT cycles.
REQ-026 SHALL, without PISO_PARITY_EN, contain no PARITY state or parity logic; the frame is as in REQ-017.

Structure
REQ-027 SHALL take the state encoding (IDLE, START, SHIFT, PARITY, STOP) and the default CYCLES_PER_BIT and DATA_W constants from shared package dice_serial_pkg, which the receiver also uses.
REQ-028 SHALL instantiate one sub-module, bit_timer, a counter parameterized by CYCLES_PER_BIT that emits a one-cycle bit_tick at each bit boundary, cleared when the main FSM is in IDLE.

Verification
REQ-029 SHALL cover, with CYCLES_PER_BIT=4 and i_data_in=7'h55: line holds 0 for 4 cycles, then 1,0,1,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; o_done pulses on cycle 36; o_ready rises on cycle 37.
REQ-030 SHALL cover a back-to-back transfer of 7'h01 then 7'h7F: exactly one idle-high cycle between frames, and both words serialize correctly.
REQ-031 SHALL cover i_start pulsed with 7'h00 during frame 7'h2A: the frame is unchanged, with no second frame and one o_done pulse.
REQ-032 SHALL cover reset_n=0 asserted in the middle of bit 3: o_data_out=1 and o_ready=1 asynchronously, with no o_done pulse; a subsequent 7'h12 transmits normally.
REQ-033 SHALL cover, with PISO_PARITY_EN and word 7'h07: parity bit=1 after bit 6, and the frame is 40 cycles at CYCLES_PER_BIT=4.
REQ-034 SHALL cover a loopback into the receiver at CYCLES_PER_BIT=10 for all 128 words: every received word matches the sent word.
